// File: rtl/vmecpld_pkg.sv
// Shared definitions for the WFD125 CPLD VME slave.
//   - A16 address modifier codes accepted by the board window
//   - register index constants (XA[3:1])
//   - bus cycle sequencer state encoding
package vmecpld_pkg;

  localparam logic [5:0] AM_USER  = 6'h29;
  localparam logic [5:0] AM_SUPER = 6'h2D;

  localparam logic [2:0] REG_ID      = 3'd0;
  localparam logic [2:0] REG_CSR     = 3'd1;
  localparam logic [2:0] REG_STAT    = 3'd2;
  localparam logic [2:0] REG_SCRATCH = 3'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEL  = 3'd1,
    ACC  = 3'd2,
    ACK  = 3'd3,
    REL  = 3'd4
  } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronised output (two clocks of latency)
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/vme_reg_ctrl.sv
// VME A16/D8 slave cycle sequencer and register file for the WFD125 CPLD.
// Decodes the board window, sequences DTACK with active release and owns
// the FPGA configuration controls (PROG_B pulse, mode pins) plus status.
//   CPLDCLK/CRST      : clock, asynchronous active-low reset
//   XA/XAM/XIACK/XGA  : address, modifier, IACK*, geographic address
//   XAS/XDS/XWRITE    : bus strobes (active low), synchronised internally
//   XD_IN/XD_OUT/XD_OE: data in, data out and its output enable
//   DDIR              : transceiver direction, high = board->bus
//   XDTACK/XDTACKOE   : DTACK level and its active-low driver enable
//   DONE/INIT         : FPGA status inputs
//   PROG/M            : FPGA PROG_B (active low) and mode pins
module vme_reg_ctrl
  import vmecpld_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR   = 12'h179,
  parameter logic [5:0]  AM_USER     = vmecpld_pkg::AM_USER,
  parameter logic [5:0]  AM_SUPER    = vmecpld_pkg::AM_SUPER,
  parameter int          TIMEOUT     = 255,
  parameter int          PROG_CYCLES = 64
) (
  input  logic        CPLDCLK,
  input  logic        CRST,
  input  logic [15:0] XA,
  input  logic [5:0]  XAM,
  input  logic        XAS,
  input  logic [1:0]  XDS,
  input  logic        XWRITE,
  input  logic        XIACK,
  input  logic [5:0]  XGA,
  input  logic [7:0]  XD_IN,
  output logic [7:0]  XD_OUT,
  output logic        XD_OE,
  output logic        DDIR,
  output logic        XDTACK,
  output logic        XDTACKOE,
  input  logic        DONE,
  input  logic        INIT,
  output logic        PROG,
  output logic [1:0]  M
);

  localparam int             PW     = $clog2(PROG_CYCLES + 1);
  localparam logic [PW-1:0]  PC_LD  = PW'(PROG_CYCLES);
  localparam logic [7:0]     TO_CNT = 8'(TIMEOUT);

  logic as_s, ds_s, wr_s;

  sync2 #(.RST_VAL(1'b1)) u_sync_as (.clk(CPLDCLK), .rst_n(CRST), .d(XAS),    .q(as_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_ds (.clk(CPLDCLK), .rst_n(CRST), .d(XDS[0]), .q(ds_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_wr (.clk(CPLDCLK), .rst_n(CRST), .d(XWRITE), .q(wr_s));

  // D8 odd-byte only: the even strobe and A0 carry no information here.
  logic unused_bits;
  assign unused_bits = ^{XDS[1], XA[0]};

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            armed_q, armed_d;
  logic [2:0]      idx_q, idx_d;
  logic            rd_q, rd_d;
  logic [7:0]      scratch_q, scratch_d;
  logic [1:0]      m_q, m_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic            prog_q, prog_d;
  logic [7:0]      xd_out_q, xd_out_d;
  logic            xd_oe_q, xd_oe_d;
  logic            ddir_q, ddir_d;
  logic            dtack_q, dtack_d;
  logic            dtackoe_q, dtackoe_d;

  logic            hit;
  logic            prog_busy;
  logic [7:0]      rd_data;

  assign prog_busy = (pcnt_q != '0);

  // armed_q blocks re-decoding the same strobe: AS must be seen high
  // between one accepted cycle and the next.
  assign hit = armed_q && !as_s && XIACK &&
               ((XAM == AM_USER) || (XAM == AM_SUPER)) &&
               (XA[15:4] == BASE_ADDR);

  always_comb begin
    rd_data = 8'h00;
    case (idx_q)
      REG_ID:      rd_data = {2'b00, XGA};
      REG_CSR:     rd_data = {5'b0, m_q, prog_busy};
      REG_STAT:    rd_data = {5'b0, prog_busy, INIT, DONE};
      REG_SCRATCH: rd_data = scratch_q;
      default:     rd_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rd_d      = rd_q;
    scratch_d = scratch_q;
    m_d       = m_q;
    pcnt_d    = prog_busy ? (pcnt_q - PW'(1)) : pcnt_q;
    xd_out_d  = xd_out_q;
    xd_oe_d   = xd_oe_q;
    ddir_d    = ddir_q;
    dtack_d   = dtack_q;
    dtackoe_d = dtackoe_q;

    unique case (state_q)
      IDLE: begin
        if (hit) begin
          state_d = SEL;
          idx_d   = XA[3:1];
          rd_d    = wr_s;
        end
      end
      SEL: begin
        if (as_s)                 state_d = IDLE;
        else if (!ds_s)           state_d = ACC;
        else if (cnt_q == TO_CNT) state_d = IDLE;
      end
      ACC: begin
        state_d   = ACK;
        dtackoe_d = 1'b0;
        dtack_d   = 1'b0;
        if (rd_q) begin
          xd_out_d = rd_data;
          xd_oe_d  = 1'b1;
          ddir_d   = 1'b1;
        end else begin
          case (idx_q)
            REG_CSR: begin
              m_d = XD_IN[2:1];
              // A request while the pulse is running must not restart it.
              if (XD_IN[0] && !prog_busy) pcnt_d = PC_LD;
            end
            REG_SCRATCH: scratch_d = XD_IN;
            default: ;
          endcase
        end
      end
      ACK: begin
        if (ds_s || (cnt_q == TO_CNT)) begin
          state_d = REL;
          // Drive DTACK high for one cycle before tri-stating it.
          dtack_d = 1'b1;
          xd_oe_d = 1'b0;
          ddir_d  = 1'b0;
        end
      end
      REL: begin
        state_d   = IDLE;
        dtackoe_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q)  cnt_d = 8'h00;
    else if (cnt_q == 8'hFF) cnt_d = cnt_q;
    else                     cnt_d = cnt_q + 8'h01;

    if (as_s)                          armed_d = 1'b1;
    else if ((state_q == IDLE) && hit) armed_d = 1'b0;
    else                               armed_d = armed_q;

    prog_d = (pcnt_d == '0);
  end

  always_ff @(posedge CPLDCLK or negedge CRST) begin
    if (!CRST) begin
      state_q   <= IDLE;
      cnt_q     <= 8'h00;
      armed_q   <= 1'b0;
      idx_q     <= 3'd0;
      rd_q      <= 1'b0;
      scratch_q <= 8'h00;
      m_q       <= 2'b11;
      pcnt_q    <= '0;
      prog_q    <= 1'b1;
      xd_out_q  <= 8'h00;
      xd_oe_q   <= 1'b0;
      ddir_q    <= 1'b0;
      dtack_q   <= 1'b1;
      dtackoe_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      idx_q     <= idx_d;
      rd_q      <= rd_d;
      scratch_q <= scratch_d;
      m_q       <= m_d;
      pcnt_q    <= pcnt_d;
      prog_q    <= prog_d;
      xd_out_q  <= xd_out_d;
      xd_oe_q   <= xd_oe_d;
      ddir_q    <= ddir_d;
      dtack_q   <= dtack_d;
      dtackoe_q <= dtackoe_d;
    end
  end

  assign XD_OUT   = xd_out_q;
  assign XD_OE    = xd_oe_q;
  assign DDIR     = ddir_q;
  assign XDTACK   = dtack_q;
  assign XDTACKOE = dtackoe_q;
  assign PROG     = prog_q;
  assign M        = m_q;

endmodule

// File: tb/tb_vme_reg_ctrl.sv
// Directed bench for vme_reg_ctrl: VME A16/D8 read/write cycles, window
// misses, PROG pulse, strobe timeouts and reset in the middle of a cycle.
module tb_vme_reg_ctrl;

  logic        CPLDCLK = 1'b0;
  logic        CRST;
  logic [15:0] XA;
  logic [5:0]  XAM;
  logic        XAS;
  logic [1:0]  XDS;
  logic        XWRITE;
  logic        XIACK;
  logic [5:0]  XGA;
  logic [7:0]  XD_IN;
  logic [7:0]  XD_OUT;
  logic        XD_OE;
  logic        DDIR;
  logic        XDTACK;
  logic        XDTACKOE;
  logic        DONE;
  logic        INIT;
  logic        PROG;
  logic [1:0]  M;

  vme_reg_ctrl dut (
    .CPLDCLK (CPLDCLK),
    .CRST    (CRST),
    .XA      (XA),
    .XAM     (XAM),
    .XAS     (XAS),
    .XDS     (XDS),
    .XWRITE  (XWRITE),
    .XIACK   (XIACK),
    .XGA     (XGA),
    .XD_IN   (XD_IN),
    .XD_OUT  (XD_OUT),
    .XD_OE   (XD_OE),
    .DDIR    (DDIR),
    .XDTACK  (XDTACK),
    .XDTACKOE(XDTACKOE),
    .DONE    (DONE),
    .INIT    (INIT),
    .PROG    (PROG),
    .M       (M)
  );

  always #5 CPLDCLK = ~CPLDCLK;

  int n_cmp = 0;
  int n_bad = 0;
  int prog_low = 0;

  always @(negedge CPLDCLK) if (PROG === 1'b0) prog_low++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present address, assert AS, give the slave time to reach SEL, then DS.
  task automatic begin_cycle(input logic [15:0] a, input logic [5:0] am,
                             input logic iack, input logic wr, input logic [7:0] din);
    @(negedge CPLDCLK);
    XA = a; XAM = am; XIACK = iack; XWRITE = wr ? 1'b0 : 1'b1; XD_IN = din;
    XAS = 1'b0;
    repeat (4) @(negedge CPLDCLK);
    XDS = 2'b10;
  endtask

  task automatic wait_dtack(input logic lvl, input int budget, output int n);
    n = 0;
    while (XDTACK !== lvl && n < budget) begin
      @(negedge CPLDCLK);
      n++;
    end
  endtask

  task automatic end_cycle();
    XDS = 2'b11;
    @(negedge CPLDCLK);
    XAS = 1'b1; XIACK = 1'b1; XWRITE = 1'b1;
    repeat (4) @(negedge CPLDCLK);
  endtask

  task automatic bus_cycle(input string tag, input logic [15:0] a, input logic [5:0] am,
                           input logic iack, input logic wr, input logic [7:0] din,
                           input logic exp_ack, input logic [7:0] exp_rd);
    int  n;
    logic seen;
    begin_cycle(a, am, iack, wr, din);
    if (exp_ack) begin
      wait_dtack(1'b0, 40, n);
      check_eq({tag, "_lat"}, n, 4);
      check_eq({tag, "_oe"}, XDTACKOE, 1'b0);
      if (!wr) begin
        check_eq({tag, "_data"}, XD_OUT, exp_rd);
        check_eq({tag, "_drv"}, {XD_OE, DDIR}, 2'b11);
      end
      repeat (3) @(negedge CPLDCLK);
      check_eq({tag, "_hold"}, XDTACK, 1'b0);
      XDS = 2'b11;
      wait_dtack(1'b1, 40, n);
      check_eq({tag, "_rel"}, {XDTACK, XDTACKOE, XD_OE, DDIR}, 4'b1000);
      @(negedge CPLDCLK);
      check_eq({tag, "_idle"}, XDTACKOE, 1'b1);
    end else begin
      seen = 1'b0;
      repeat (20) begin
        @(negedge CPLDCLK);
        if (XDTACK !== 1'b1 || XDTACKOE !== 1'b1) seen = 1'b1;
      end
      check_eq({tag, "_noack"}, seen, 1'b0);
    end
    end_cycle();
  endtask

  initial begin
    int  n;
    int  base;
    logic seen;

    CRST = 1'b0; XA = 16'h0; XAM = 6'h0; XAS = 1'b1; XDS = 2'b11; XWRITE = 1'b1;
    XIACK = 1'b1; XGA = 6'h15; XD_IN = 8'h00; DONE = 1'b1; INIT = 1'b0;

    repeat (3) @(negedge CPLDCLK);
    check_eq("reset", {XD_OUT, XD_OE, DDIR, XDTACK, XDTACKOE, PROG, M},
             {8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11});
    CRST = 1'b1;
    repeat (4) @(negedge CPLDCLK);

    bus_cycle("rd_id",      16'h1790, 6'h2D, 1'b1, 1'b0, 8'h00, 1'b1, 8'h15);
    bus_cycle("wr_scr",     16'h1796, 6'h29, 1'b1, 1'b1, 8'hA5, 1'b1, 8'h00);
    bus_cycle("rd_scr",     16'h1796, 6'h29, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA5);

    bus_cycle("miss_am",    16'h1796, 6'h39, 1'b1, 1'b1, 8'h5A, 1'b0, 8'h00);
    bus_cycle("miss_iack",  16'h1796, 6'h29, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h00);
    bus_cycle("miss_addr",  16'h1780, 6'h29, 1'b1, 1'b1, 8'h5A, 1'b0, 8'h00);
    bus_cycle("rd_scr2",    16'h1796, 6'h29, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA5);

    bus_cycle("wr_id_ro",   16'h1790, 6'h29, 1'b1, 1'b1, 8'hFF, 1'b1, 8'h00);
    bus_cycle("rd_id2",     16'h1790, 6'h29, 1'b1, 1'b0, 8'h00, 1'b1, 8'h15);
    bus_cycle("rd_idx5",    16'h179A, 6'h29, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00);

    // PROG pulse: second request lands while the first pulse is running.
    base = prog_low;
    bus_cycle("wr_csr",     16'h1792, 6'h29, 1'b1, 1'b1, 8'h03, 1'b1, 8'h00);
    check_eq("m_pins", M, 2'b01);
    bus_cycle("wr_csr2",    16'h1792, 6'h29, 1'b1, 1'b1, 8'h03, 1'b1, 8'h00);
    bus_cycle("rd_csr_bsy", 16'h1792, 6'h29, 1'b1, 1'b0, 8'h00, 1'b1, 8'h03);
    n = 0;
    while (PROG !== 1'b1 && n < 200) begin
      @(negedge CPLDCLK);
      n++;
    end
    repeat (10) @(negedge CPLDCLK);
    check_eq("prog_len", prog_low - base, 64);
    bus_cycle("rd_csr",     16'h1792, 6'h29, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02);
    bus_cycle("rd_stat",    16'h1794, 6'h29, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01);

    // DS never asserted: slave gives up, and the stale strobe is not re-decoded.
    @(negedge CPLDCLK);
    XA = 16'h1796; XAM = 6'h29; XWRITE = 1'b0; XD_IN = 8'h77; XAS = 1'b0;
    seen = 1'b0;
    repeat (300) begin
      @(negedge CPLDCLK);
      if (XDTACK !== 1'b1 || XDTACKOE !== 1'b1) seen = 1'b1;
    end
    XDS = 2'b10;
    repeat (20) begin
      @(negedge CPLDCLK);
      if (XDTACK !== 1'b1 || XDTACKOE !== 1'b1) seen = 1'b1;
    end
    check_eq("sel_timeout", seen, 1'b0);
    end_cycle();
    bus_cycle("rd_scr3",    16'h1796, 6'h29, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA5);

    // DS never released: DTACK held for 256 cycles, then active release.
    begin_cycle(16'h1790, 6'h29, 1'b1, 1'b0, 8'h00);
    wait_dtack(1'b0, 40, n);
    check_eq("ack_to_lat", n, 4);
    wait_dtack(1'b1, 400, n);
    check_eq("ack_to_len", n, 256);
    check_eq("ack_to_rel", XDTACKOE, 1'b0);
    end_cycle();

    // Reset while DTACK is asserted.
    begin_cycle(16'h1796, 6'h29, 1'b1, 1'b0, 8'h00);
    wait_dtack(1'b0, 40, n);
    check_eq("pre_rst_ack", XDTACK, 1'b0);
    CRST = 1'b0;
    #1;
    check_eq("rst_mid", {XDTACK, XDTACKOE, XD_OE, M, PROG}, {1'b1, 1'b1, 1'b0, 2'b11, 1'b1});
    XDS = 2'b11; XAS = 1'b1; XWRITE = 1'b1;
    @(negedge CPLDCLK);
    CRST = 1'b1;
    repeat (4) @(negedge CPLDCLK);
    bus_cycle("rd_scr_rst", 16'h1796, 6'h29, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
    bus_cycle("rd_id_rst",  16'h1790, 6'h2D, 1'b1, 1'b0, 8'h00, 1'b1, 8'h15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
